// File: rtl/uart_echo_responder.sv
// Far-end UART echo responder: buffers each received byte in a FIFO and re-transmits it in order,
// keeping byte counters and a sticky overflow flag for link self-test.
module uart_echo_responder #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   rx_rdy_clr,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_en,
  input  logic                   tx_busy,
  input  logic                   echo_en,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [15:0]            rx_count,
  output logic [15:0]            tx_count,
  output logic [7:0]             drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic {RxIdle, RxAckWait} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxBusyWait, TxDoneWait} tx_state_e;

  rx_state_e       rx_state_q;
  tx_state_e       tx_state_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [TW-1:0]   timer_q;

  logic fifo_full;
  logic fifo_empty;
  logic rx_take;
  logic pop;
  logic push;
  logic drop;

  // A capture into a full FIFO still fits when the head leaves on the same edge.
  always_comb begin
    fifo_full  = (fifo_level == LW'(DEPTH));
    fifo_empty = (fifo_level == '0);
    rx_take    = (rx_state_q == RxIdle) && rx_rdy;
    pop        = (tx_state_q == TxIdle) && echo_en && !fifo_empty && !tx_busy;
    push       = rx_take && (!fifo_full || pop);
    drop       = rx_take && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      tx_state_q <= TxIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      timer_q    <= '0;
      rx_rdy_clr <= 1'b0;
      tx_data    <= 8'h00;
      tx_wr_en   <= 1'b0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      rx_count   <= 16'h0000;
      tx_count   <= 16'h0000;
      drop_count <= 8'h00;
    end else begin
      rx_rdy_clr <= 1'b0;
      tx_wr_en   <= 1'b0;

      unique case (rx_state_q)
        RxIdle: begin
          if (rx_take) begin
            rx_rdy_clr <= 1'b1;
            rx_state_q <= RxAckWait;
          end
        end
        RxAckWait: begin
          if (!rx_rdy) begin
            rx_state_q <= RxIdle;
          end
        end
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        rx_count <= rx_count + 16'd1;
      end

      // A drop in the same cycle as a clear wins and restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr) begin
          drop_count <= 8'd1;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end else if (ovf_clr) begin
        overflow   <= 1'b0;
        drop_count <= 8'h00;
      end

      case (tx_state_q)
        TxIdle: begin
          if (pop) begin
            tx_data    <= mem[rd_ptr_q];
            tx_wr_en   <= 1'b1;
            tx_count   <= tx_count + 16'd1;
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            timer_q    <= '0;
            tx_state_q <= TxBusyWait;
          end
        end
        TxBusyWait: begin
          // No busy response within the window: treat the byte as sent, never retry.
          if (tx_busy) begin
            tx_state_q <= TxDoneWait;
          end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            tx_state_q <= TxIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        TxDoneWait: begin
          if (!tx_busy) begin
            tx_state_q <= TxIdle;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase

      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: randomized traffic against a queue-based transaction model,
// plus directed latency, overflow, same-cycle push/pop, timeout and reset scenarios.
module tb_uart_echo_responder;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned BUSY_TIMEOUT = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic                   rx_rdy = 1'b0;
  logic                   rx_rdy_clr;
  logic [7:0]             tx_data;
  logic                   tx_wr_en;
  logic                   tx_busy;
  logic                   echo_en = 1'b0;
  logic                   ovf_clr = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [15:0]            rx_count;
  logic [15:0]            tx_count;
  logic [7:0]             drop_count;

  always #5 clk = ~clk;

  uart_echo_responder #(
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_rdy_clr(rx_rdy_clr),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .echo_en   (echo_en),
    .ovf_clr   (ovf_clr),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Input values seen at the most recent rising edge.
  bit         prev_rst = 1'b0;
  bit         prev_echo = 1'b0;
  bit         prev_busy = 1'b0;
  bit         prev_ovf = 1'b0;
  bit         cap_now = 1'b0;
  logic [7:0] cap_byte_now = 8'h00;
  bit         cap_pending = 1'b0;
  logic [7:0] cap_byte = 8'h00;

  int busy_mode = 0;
  int busy_len_min = 1;
  int busy_len_max = 1;
  int busy_dly_max = 0;

  logic [7:0]  model_q[$];
  logic [15:0] model_rx = 16'h0;
  logic [15:0] model_tx = 16'h0;
  logic [7:0]  model_drop = 8'h0;
  bit          model_ovf = 1'b0;
  logic [7:0]  last_tx = 8'h0;
  int          last_strobe = -1000;
  int          strobe_cyc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) begin
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
    end
  endtask

  initial begin : sampler
    forever begin
      @(posedge clk);
      cyc++;
      prev_rst     = rst_n;
      prev_echo    = echo_en;
      prev_busy    = tx_busy;
      prev_ovf     = ovf_clr;
      cap_now      = cap_pending && rst_n;
      cap_byte_now = cap_byte;
    end
  end

  // Transaction model: strobes drain the queue first, then the captured byte is offered.
  initial begin : monitor
    logic [7:0] exp_b;
    bit         drop_now;
    forever begin
      @(negedge clk);
      drop_now = 1'b0;
      if (!prev_rst) begin
        model_q.delete();
        model_rx    = 16'h0;
        model_tx    = 16'h0;
        model_drop  = 8'h0;
        model_ovf   = 1'b0;
        last_tx     = 8'h0;
        last_strobe = -1000;
        check_eq("wr_en_in_reset", tx_wr_en, 0);
      end else begin
        if (tx_wr_en) begin
          check_eq("launch_gate", {prev_echo, prev_busy}, 2'b10);
          check_eq("strobe_spacing", (cyc - last_strobe) >= 3, 1);
          check_eq("strobe_has_data", model_q.size() != 0, 1);
          if (model_q.size() != 0) begin
            exp_b = model_q.pop_front();
            check_eq("echo_byte", tx_data, exp_b);
            last_tx = exp_b;
          end
          model_tx    = model_tx + 16'd1;
          last_strobe = cyc;
          strobe_cyc_q.push_back(cyc);
        end
        if (cap_now) begin
          if (model_q.size() < int'(DEPTH)) begin
            model_q.push_back(cap_byte_now);
            model_rx = model_rx + 16'd1;
          end else begin
            drop_now = 1'b1;
          end
        end
        if (drop_now) begin
          model_ovf  = 1'b1;
          model_drop = prev_ovf ? 8'd1 : ((model_drop == 8'hFF) ? 8'hFF : model_drop + 8'd1);
        end else if (prev_ovf) begin
          model_ovf  = 1'b0;
          model_drop = 8'h0;
        end
      end
      check_eq("rx_rdy_clr", rx_rdy_clr, cap_now);
      check_eq("fifo_level", fifo_level, model_q.size());
      check_eq("overflow", overflow, model_ovf);
      check_eq("rx_count", rx_count, model_rx);
      check_eq("tx_count", tx_count, model_tx);
      check_eq("drop_count", drop_count, model_drop);
      check_eq("tx_data_hold", tx_data, last_tx);
    end
  end

  // Transmitter stand-in: mode 1 raises busy after a random delay for a random length.
  initial begin : busy_model
    int d;
    int len;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_mode == 1 && tx_wr_en) begin
        d   = $urandom_range(busy_dly_max, 0);
        len = $urandom_range(busy_len_max, busy_len_min);
        repeat (d) @(negedge clk);
        tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        tx_busy = 1'b0;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit with_clr, input int hold);
    rx_data     = b;
    rx_rdy      = 1'b1;
    cap_byte    = b;
    cap_pending = 1'b1;
    if (with_clr) ovf_clr = 1'b1;
    @(negedge clk);
    cap_pending = 1'b0;
    if (with_clr) ovf_clr = 1'b0;
    repeat (hold) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    echo_en     = 1'b0;
    ovf_clr     = 1'b0;
    cap_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (model_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", model_q.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic set_busy(input int mode, input int lmin, input int lmax, input int dmax);
    busy_mode    = mode;
    busy_len_min = lmin;
    busy_len_max = lmax;
    busy_dly_max = dmax;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] burst [5];
    int t0;
    burst = '{8'hA5, 8'h5A, 8'hCB, 8'hFF, 8'h00};

    do_reset();
    check_eq("reset_level", fifo_level, 0);
    check_eq("reset_tx_data", tx_data, 0);
    check_eq("reset_counts", {rx_count, tx_count}, 0);

    // Single byte and rx_rdy-to-strobe latency.
    set_busy(1, 3, 3, 0);
    echo_en = 1'b1;
    strobe_cyc_q.delete();
    t0 = cyc;
    send_byte(8'hA5, 1'b0, 0);
    wait_drain();
    check_eq("single_strobes", strobe_cyc_q.size(), 1);
    if (strobe_cyc_q.size() >= 1) check_eq("single_latency", strobe_cyc_q[0] - t0, 2);
    check_eq("single_data", tx_data, 8'hA5);
    check_eq("single_rx_count", rx_count, 1);
    check_eq("single_tx_count", tx_count, 1);

    // In-order burst with a randomly slow transmitter.
    do_reset();
    set_busy(1, 1, 8, 2);
    echo_en = 1'b1;
    foreach (burst[i]) begin
      send_byte(burst[i], 1'b0, $urandom_range(2, 0));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_drain();
    check_eq("burst_rx_count", rx_count, 5);
    check_eq("burst_tx_count", tx_count, 5);
    check_eq("burst_overflow", overflow, 0);

    // Overflow with echo held off, then clear-vs-drop priority.
    do_reset();
    set_busy(0, 1, 1, 0);
    for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b0, 0);
    check_eq("ovf_level", fifo_level, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drops", drop_count, 2);
    send_byte(8'h0B, 1'b1, 0);
    check_eq("ovf_clr_drop_cnt", drop_count, 1);
    check_eq("ovf_clr_drop_flag", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", {overflow, drop_count}, 0);
    echo_en = 1'b1;
    wait_drain();
    check_eq("ovf_tx_count", tx_count, 8);

    // Push and pop on the same edge with the FIFO full.
    do_reset();
    set_busy(0, 1, 1, 0);
    for (int i = 0; i < int'(DEPTH); i++) send_byte(8'($urandom), 1'b0, 0);
    check_eq("pp_full", fifo_level, 8);
    echo_en = 1'b1;
    send_byte(8'hC3, 1'b0, 0);
    check_eq("pp_level", fifo_level, 8);
    check_eq("pp_drops", drop_count, 0);
    check_eq("pp_rx_count", rx_count, 9);
    wait_drain();
    check_eq("pp_tx_count", tx_count, 9);

    // Busy timeout: transmitter never answers.
    do_reset();
    set_busy(0, 1, 1, 0);
    echo_en = 1'b1;
    strobe_cyc_q.delete();
    send_byte(8'($urandom), 1'b0, 0);
    send_byte(8'($urandom), 1'b0, 0);
    wait_drain();
    check_eq("to_strobes", strobe_cyc_q.size(), 2);
    if (strobe_cyc_q.size() >= 2) begin
      check_eq("to_spacing", strobe_cyc_q[1] - strobe_cyc_q[0], BUSY_TIMEOUT + 1);
    end

    // Drop counter saturation.
    do_reset();
    set_busy(0, 1, 1, 0);
    for (int i = 0; i < 268; i++) send_byte(8'($urandom), 1'b0, 0);
    check_eq("sat_drops", drop_count, 8'hFF);
    check_eq("sat_rx_count", rx_count, 8);
    echo_en = 1'b1;
    wait_drain();

    // Reset while the transmitter is busy with three bytes queued.
    do_reset();
    set_busy(1, 40, 40, 0);
    echo_en = 1'b1;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b0, 0);
    check_eq("rst_queued", fifo_level, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_outs_a", {tx_data, tx_wr_en, rx_rdy_clr, overflow, drop_count}, 0);
    check_eq("rst_outs_b", {fifo_level, rx_count, tx_count}, 0);
    strobe_cyc_q.delete();
    repeat (60) @(negedge clk);
    check_eq("rst_no_strobe", strobe_cyc_q.size(), 0);
    send_byte(8'h55, 1'b0, 0);
    wait_drain();
    check_eq("rst_new_strobe", strobe_cyc_q.size(), 1);

    // Randomized traffic with echo gating, clears and drops.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) set_busy(1, 1, 6, 2);
      else set_busy(0, 1, 1, 0);
      echo_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
        send_byte(8'($urandom), 1'b0, $urandom_range(2, 0));
        repeat ($urandom_range(4, 0)) begin
          if ($urandom_range(7, 0) == 0) echo_en = ~echo_en;
          ovf_clr = ($urandom_range(15, 0) == 0);
          @(negedge clk);
        end
        ovf_clr = 1'b0;
      end
      echo_en = 1'b1;
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end responder for the UART link: takes each byte completed by the receiver half of `uart_top` and sends it back out through the transmitter half, in arrival order. It sits between the receiver's `rx_data_out`/`rx_rdy_out`/`rx_rdy_clr` handshake and the transmitter's `tx_data_in`/`tx_wr_en`/`tx_busy_out` handshake. An internal FIFO absorbs bytes that arrive while the transmitter is busy. It also keeps byte counters and a sticky overflow flag for link self-test.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, 2..256.
- `BUSY_TIMEOUT`, 4: cycles to wait for `tx_busy` to rise after a write strobe.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `rx_data` in 8: received byte, valid while `rx_rdy`=1.
- `rx_rdy` in 1: receiver byte-ready level; held until cleared.
- `rx_rdy_clr` out 1: one-cycle pulse acknowledging `rx_rdy`.
- `tx_data` out 8: byte to transmit.
- `tx_wr_en` out 1: one-cycle transmit strobe.
- `tx_busy` in 1: transmitter busy level.
- `echo_en` in 1: 1 = launch transmissions; 0 = hold bytes in FIFO.
- `ovf_clr` in 1: clears `overflow` and `drop_count`.
- `fifo_level` out $clog2(DEPTH)+1: bytes currently buffered.
- `overflow` out 1: sticky; set when a byte was dropped.
- `rx_count` out 16: bytes accepted, wraps at 0xFFFF→0.
- `tx_count` out 16: bytes launched, wraps.
- `drop_count` out 8: bytes dropped; saturates at 0xFF.

## Operation
- **Reset** (`rst_n`=0 at a clk edge):
  - Every output goes to 0, including `tx_data`=0x00.
  - FIFO is emptied.
  - Both FSMs go to their idle states.
  - This applies mid-transfer too: a byte in flight is abandoned and no further strobes are issued.
- **RX FSM**, states `RX_IDLE` and `RX_ACK_WAIT`:
  - `RX_IDLE` with `rx_rdy`=1: capture `rx_data`, pulse `rx_rdy_clr` for exactly one cycle, go to `RX_ACK_WAIT`.
  - Captured byte when FIFO not full: push; `rx_count`+1.
  - Captured byte when FIFO full: discard; set `overflow`; `drop_count`+1 (saturating). `rx_count` is unchanged.
  - `RX_ACK_WAIT`: stay until `rx_rdy`=0, then go to `RX_IDLE`. This guarantees one capture per byte even if `rx_rdy` falls late.
- **TX FSM**, states `TX_IDLE`, `TX_BUSY_WAIT`, `TX_DONE_WAIT`:
  - `TX_IDLE` launches only when all hold: `echo_en`=1, FIFO not empty, `tx_busy`=0.
  - On launch: pop the FIFO head, register it onto `tx_data`, pulse `tx_wr_en` for one cycle, `tx_count`+1, go to `TX_BUSY_WAIT`.
  - `TX_BUSY_WAIT`: go to `TX_DONE_WAIT` on `tx_busy`=1. Return to `TX_IDLE` after `BUSY_TIMEOUT` cycles without it; the byte counts as sent and is not retried.
  - `TX_DONE_WAIT`: go to `TX_IDLE` when `tx_busy`=0.
  - `tx_data` holds its value from the strobe until the next launch.
- `echo_en` is sampled only in `TX_IDLE`. Deasserting it does not abort a launched byte.
- **FIFO push and pop**:
  - Push and pop in the same cycle are both performed and `fifo_level` is unchanged.
  - A push to a full FIFO that coincides with a pop is accepted, not dropped. "Full" is evaluated after the pop.
  - Pointers wrap modulo `DEPTH`.
- `ovf_clr`=1 clears `overflow` and `drop_count` on the next edge. If a drop occurs in the same cycle, set wins: `overflow`=1 and `drop_count`=1.

## Timing
- All outputs are registered.
- `rx_rdy` rises at cycle N:
  - `rx_rdy_clr`=1 during N+1.
  - Byte is in the FIFO and `fifo_level` updated at N+1.
- Latency from `rx_rdy` to `tx_wr_en` is 2 cycles when the FIFO was empty, `tx_busy`=0 and `echo_en`=1.
  - Push at N+1, launch decision in N+1, `tx_wr_en`=1 during N+2.
- Minimum spacing between consecutive `tx_wr_en` pulses is 3 cycles; actual spacing is governed by `tx_busy`.
- `rx_rdy_clr` minimum spacing is 2 cycles.

## Test plan
- **Single byte**: reset, then present `rx_data`=0xA5 with `rx_rdy`=1.
  - `rx_rdy_clr` pulses once.
  - `tx_wr_en` pulses 2 cycles after `rx_rdy` with `tx_data`=0xA5.
  - `rx_count`=`tx_count`=1.
- **In-order burst**: run the loopback through `uart_top` at 9600 baud with bytes 0xA5, 0x5A, 0xCB, 0xFF, 0x00.
  - All five are echoed in order.
  - `overflow`=0 and both counters read 5.
- **Overflow**: hold `echo_en`=0 and feed 10 bytes 0x01..0x0A with `DEPTH`=8.
  - `fifo_level`=8, `overflow`=1, `drop_count`=2.
  - Then raise `echo_en`: exactly 0x01..0x08 are echoed.
- **Push/pop same cycle with full FIFO**: a new byte and a pop land in the same cycle.
  - The byte is accepted, `fifo_level` stays 8, and `drop_count` is unchanged.
- **Busy timeout**: tie `tx_busy`=0 and feed 2 bytes.
  - The second `tx_wr_en` comes `BUSY_TIMEOUT`+1 cycles after the first.
- **Reset mid-operation**: assert `rst_n`=0 while in `TX_DONE_WAIT` with 3 bytes queued.
  - All outputs read 0 on the next edge.
  - No `tx_wr_en` occurs after reset is released until a new `rx_rdy` arrives.
